// File: rtl/seg_pkg.sv
// Shared widths, default limits and the wrapping increment used by the
// seven-segment test-pattern source.
package seg_pkg;

  localparam int DATA_W = 20;
  localparam int DIGITS = 6;
  localparam int CNT_W  = 23;

  localparam logic [CNT_W-1:0]  CNT_MAX_DEF  = 23'd4_999_999;
  localparam logic [DATA_W-1:0] DATA_MAX_DEF = 20'd999_999;

  // Next counter value, returning to zero once the terminal value is reached.
  function automatic logic [DATA_W-1:0] wrap_inc(input logic [DATA_W-1:0] value,
                                                 input logic [DATA_W-1:0] max_value);
    logic [DATA_W-1:0] result;
    if (value == max_value) begin
      result = 20'd0;
    end else begin
      result = value + 20'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-clock tick every CNT_MAX+1 clocks; the tick is
// registered so it is high in the cycle where the prescaler sits at CNT_MAX.
module tick_gen
  import seg_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic tick
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             tick_r;
  logic             tick_nxt_s;

  // Prescaler next state and early terminal-count decode.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    tick_nxt_s = 1'b0;
    if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + 23'd1;
    end
    if (cnt_r == (CNT_MAX - 23'd1)) begin
      tick_nxt_s = 1'b1;
    end else begin
      tick_nxt_s = 1'b0;
    end
  end

  // Prescaler and tick registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= tick_nxt_s;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/data_gen.sv
// Decimal test-pattern source for the six-digit display: a 0..DATA_MAX counter
// advanced on every prescaler tick, plus constant point/sign and a display enable.
module data_gen
  import seg_pkg::*;
#(
  parameter logic [CNT_W-1:0]  CNT_MAX  = CNT_MAX_DEF,
  parameter logic [DATA_W-1:0] DATA_MAX = DATA_MAX_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  output logic [DATA_W-1:0] data,
  output logic [DIGITS-1:0] point,
  output logic              sign,
  output logic              seg_en
);

  logic              tick_s;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] data_nxt_s;
  logic [DIGITS-1:0] point_r;
  logic              sign_r;
  logic              seg_en_r;

  tick_gen #(
    .CNT_MAX (CNT_MAX)
  ) u_tick_gen (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .tick    (tick_s)
  );

  // Data counter advances only on a tick and never exceeds DATA_MAX.
  always_comb begin
    data_nxt_s = data_r;
    if (tick_s) begin
      data_nxt_s = wrap_inc(data_r, DATA_MAX);
    end else begin
      data_nxt_s = data_r;
    end
  end

  // Output registers; the enable rises on the first edge out of reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      data_r   <= {DATA_W{1'b0}};
      point_r  <= {DIGITS{1'b0}};
      sign_r   <= 1'b0;
      seg_en_r <= 1'b0;
    end else begin
      data_r   <= data_nxt_s;
      point_r  <= {DIGITS{1'b0}};
      sign_r   <= 1'b0;
      seg_en_r <= 1'b1;
    end
  end

  assign data   = data_r;
  assign point  = point_r;
  assign sign   = sign_r;
  assign seg_en = seg_en_r;

endmodule

// File: tb/tb_data_gen.sv
// Scoreboard bench for data_gen with small limits (CNT_MAX=9, DATA_MAX=5):
// expected outputs come from the edge count since reset release.
module tb_data_gen;

  localparam int C_MAX = 9;
  localparam int D_MAX = 5;

  logic        sys_clk;
  logic        sys_rst;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;

  typedef struct {
    int   data;
    logic tick;
    logic seg_en;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   k        = 0;
  bit   in_reset = 1'b1;

  data_gen #(
    .CNT_MAX  (23'd9),
    .DATA_MAX (20'd5)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .data    (data),
    .point   (point),
    .sign    (sign),
    .seg_en  (seg_en)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge k=%0d, t=%0t)", name, act, exp_v, k, $time);
    end
  endtask

  // Drive reset for one edge, then predict the outputs after that edge.
  task automatic step(input logic r);
    exp_t e;
    @(negedge sys_clk);
    sys_rst = r;
    @(posedge sys_clk);
    if (r) begin
      k = 0;
      in_reset = 1'b1;
      e.data = 0;
      e.tick = 1'b0;
      e.seg_en = 1'b0;
    end else begin
      k++;
      in_reset = 1'b0;
      e.data = (k / (C_MAX + 1)) % (D_MAX + 1);
      e.tick = ((k % (C_MAX + 1)) == C_MAX);
      e.seg_en = 1'b1;
    end
    q.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest prediction on each falling edge.
  always @(negedge sys_clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("data", int'(data), e.data);
      check("tick", int'(dut.u_tick_gen.tick), int'(e.tick));
      check("seg_en", int'(seg_en), int'(e.seg_en));
      check("point", int'(point), 0);
      check("sign", int'(sign), 0);
    end
  end

  initial begin
    sys_rst = 1'b1;
    // Reset hold.
    repeat (5) step(1'b1);
    // Release and run to data=3, cnt=5, then a single-cycle reset.
    repeat (35) step(1'b0);
    step(1'b1);
    // Long run through several wraps of the small DATA_MAX.
    repeat (200) step(1'b0);
    // Random occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
    end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
